// File: rtl/drv_prsnt_debounce.sv
// Debounces the drive PRSNT/IDENT sample vectors once per sample tick, latches
// sticky W1C change flags and drives a maskable active-low interrupt.
module drv_prsnt_debounce #(
  parameter int          NUM_DRV    = 36,
  parameter logic [31:0] SAMPLE_DIV = 32'd2500000,
  parameter int          DEB_CNT    = 3
) (
  input  logic               SYSCLK,
  input  logic               RESET_N,
  input  logic [NUM_DRV-1:0] PRSNT,
  input  logic [NUM_DRV-1:0] IDENT,
  input  logic [NUM_DRV-1:0] CHG_CLR,
  input  logic [NUM_DRV-1:0] INT_MASK,
  output logic [NUM_DRV-1:0] PRSNT_DEB,
  output logic [NUM_DRV-1:0] IDENT_DEB,
  output logic [NUM_DRV-1:0] PRSNT_CHG,
  output logic [NUM_DRV-1:0] IDENT_CHG,
  output logic               INIT_DONE,
  output logic               INT_N
);

  localparam logic [3:0] CNT_LAST = 4'(DEB_CNT - 1);

  logic [31:0]        smp_cnt_q, smp_cnt_d;
  logic               tick_s;
  logic               init_done_q, init_done_d;
  logic [NUM_DRV-1:0] p_deb_q, p_deb_d, i_deb_q, i_deb_d;
  logic [NUM_DRV-1:0] p_chg_q, p_chg_d, i_chg_q, i_chg_d;
  logic [NUM_DRV-1:0] p_set_s, i_set_s;
  logic [3:0]         p_cnt_q [NUM_DRV];
  logic [3:0]         p_cnt_d [NUM_DRV];
  logic [3:0]         i_cnt_q [NUM_DRV];
  logic [3:0]         i_cnt_d [NUM_DRV];
  logic               int_n_q, int_n_d;

  // One debounce step for a single bit: returns {flip, next stability count}.
  function automatic logic [4:0] deb_step(input logic raw, input logic deb,
                                          input logic [3:0] cnt);
    logic [4:0] res;
    if (raw == deb) begin
      res = {1'b0, 4'd0};
    end else if (cnt >= CNT_LAST) begin
      res = {1'b1, 4'd0};
    end else begin
      res = {1'b0, cnt + 4'd1};
    end
    return res;
  endfunction

  assign tick_s = (smp_cnt_q == (SAMPLE_DIV - 32'd1));

  // Sample timer, snapshot/debounce, flag and interrupt next-state logic.
  always_comb begin
    logic [4:0] p_res, i_res;
    smp_cnt_d   = tick_s ? 32'd0 : (smp_cnt_q + 32'd1);
    init_done_d = init_done_q;
    p_deb_d     = p_deb_q;
    i_deb_d     = i_deb_q;
    p_cnt_d     = p_cnt_q;
    i_cnt_d     = i_cnt_q;
    p_set_s     = '0;
    i_set_s     = '0;
    p_res       = 5'd0;
    i_res       = 5'd0;
    if (tick_s && !init_done_q) begin
      // Initial snapshot loads directly and reports no events.
      p_deb_d     = PRSNT;
      i_deb_d     = IDENT;
      init_done_d = 1'b1;
    end else if (tick_s) begin
      for (int i = 0; i < NUM_DRV; i++) begin
        p_res      = deb_step(PRSNT[i], p_deb_q[i], p_cnt_q[i]);
        i_res      = deb_step(IDENT[i], i_deb_q[i], i_cnt_q[i]);
        p_set_s[i] = p_res[4];
        i_set_s[i] = i_res[4];
        p_deb_d[i] = p_deb_q[i] ^ p_res[4];
        i_deb_d[i] = i_deb_q[i] ^ i_res[4];
        p_cnt_d[i] = p_res[3:0];
        i_cnt_d[i] = i_res[3:0];
      end
    end else begin
      init_done_d = init_done_q;
    end
    // A set in the same cycle as a clear wins.
    p_chg_d = (p_chg_q & ~CHG_CLR) | p_set_s;
    i_chg_d = (i_chg_q & ~CHG_CLR) | i_set_s;
    int_n_d = ~|((p_chg_q | i_chg_q) & ~INT_MASK);
  end

  // State registers.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      smp_cnt_q   <= 32'd0;
      init_done_q <= 1'b0;
      p_deb_q     <= '0;
      i_deb_q     <= '0;
      p_chg_q     <= '0;
      i_chg_q     <= '0;
      int_n_q     <= 1'b1;
      for (int i = 0; i < NUM_DRV; i++) begin
        p_cnt_q[i] <= 4'd0;
        i_cnt_q[i] <= 4'd0;
      end
    end else begin
      smp_cnt_q   <= smp_cnt_d;
      init_done_q <= init_done_d;
      p_deb_q     <= p_deb_d;
      i_deb_q     <= i_deb_d;
      p_chg_q     <= p_chg_d;
      i_chg_q     <= i_chg_d;
      int_n_q     <= int_n_d;
      for (int i = 0; i < NUM_DRV; i++) begin
        p_cnt_q[i] <= p_cnt_d[i];
        i_cnt_q[i] <= i_cnt_d[i];
      end
    end
  end

  assign PRSNT_DEB = p_deb_q;
  assign IDENT_DEB = i_deb_q;
  assign PRSNT_CHG = p_chg_q;
  assign IDENT_CHG = i_chg_q;
  assign INIT_DONE = init_done_q;
  assign INT_N     = int_n_q;

endmodule

// File: doc/drv_prsnt_debounce.md
Name: drv_prsnt_debounce

Overview:
- Downstream consumer of the drive present/identify LED controller's 36-bit PRSNT and IDENT sample vectors.
- Debounces each bit over several consecutive sample ticks and publishes stable per-drive presence/identify state.
- Latches per-drive change events into sticky write-1-to-clear status.
- Drives an active-low, maskable interrupt toward the BMC register block.

Parameters:
- NUM_DRV, 36, number of drive slots (vector width).
- SAMPLE_DIV, 32'd2500000, SYSCLK cycles between sample ticks; legal range >= 2.
- DEB_CNT, 3, consecutive differing samples required before a debounced bit flips; legal range 1..15.

Ports:
- SYSCLK  input  1  system clock
- RESET_N  input  1  asynchronous active-low reset
- PRSNT  input  NUM_DRV  raw presence samples, 1 = drive present; same clock domain, no synchronizer
- IDENT  input  NUM_DRV  raw identify samples; same clock domain
- CHG_CLR  input  NUM_DRV  one-cycle W1C pulses; clears the matching PRSNT_CHG and IDENT_CHG bits
- INT_MASK  input  NUM_DRV  1 = suppress the interrupt contribution of that drive
- PRSNT_DEB  output  NUM_DRV  debounced presence
- IDENT_DEB  output  NUM_DRV  debounced identify
- PRSNT_CHG  output  NUM_DRV  sticky flag: debounced presence changed
- IDENT_CHG  output  NUM_DRV  sticky flag: debounced identify changed
- INIT_DONE  output  1  high once the initial snapshot is loaded
- INT_N  output  1  active-low interrupt

Behaviour:
Reset:
- All outputs 0 except INT_N = 1.
- Sample counter 0; all per-bit stability counters 0.

Sample timer:
- Counts 0..SAMPLE_DIV-1, then wraps to 0.
- TICK is an internal one-cycle pulse in the cycle the counter equals SAMPLE_DIV-1.
- First TICK occurs SAMPLE_DIV cycles after reset release.

Init snapshot (first TICK after reset):
- PRSNT_DEB <= PRSNT and IDENT_DEB <= IDENT directly.
- No CHG flags set; INIT_DONE <= 1 and stays 1 until the next reset.

Per-bit debounce (every later TICK), independently for each PRSNT and IDENT bit:
- raw == deb: stability counter <= 0.
- raw != deb and counter < DEB_CNT-1: counter <= counter+1.
- raw != deb and counter == DEB_CNT-1:
  - deb <= raw;
  - counter <= 0;
  - the matching CHG bit <= 1.
- A glitch lasting fewer than DEB_CNT consecutive ticks never reaches deb; any matching sample restarts the count.
- Latency: a raw change stable from a tick onward updates deb on the DEB_CNT-th tick, counting that tick as 1.
- Between ticks, raw inputs are ignored entirely.

CHG flags:
- Set only by debounced transitions, in either direction (insert and remove both flag).
- Cleared by the matching CHG_CLR bit.
- Set and clear in the same cycle: set wins, flag stays 1.

Interrupt:
- INT_N <= ~|((PRSNT_CHG | IDENT_CHG) & ~INT_MASK).
- Registered: one cycle after the flag/mask change.
- Masking does not clear flags; unmasking a flagged bit asserts INT_N on the next cycle.

Reset mid-operation:
- Asynchronous return to reset values; pending counts are discarded.
- A new init snapshot is taken with no events reported.

Test Plan:
SAMPLE_DIV=8, DEB_CNT=3, ticks at cycles 7, 15, 23, ... after reset release.
- Init: PRSNT=36'h0_0000_0005, IDENT=0 at reset release -> at cycle 8, PRSNT_DEB=36'h5, INIT_DONE=1, PRSNT_CHG=0, INT_N=1.
- Insert: after init, set PRSNT[4]=1 before tick 2 and hold -> PRSNT_DEB[4]=1 and PRSNT_CHG[4]=1 after tick 4; INT_N=0 one cycle later.
- Glitch reject: PRSNT[9]=1 for ticks 2-3, 0 at tick 4, 1 for ticks 5-6 -> PRSNT_DEB[9] stays 0, PRSNT_CHG[9]=0 throughout.
- Clear race: PRSNT_CHG[4]=1, pulse CHG_CLR[4] in the same cycle that IDENT_CHG[4] sets -> PRSNT_CHG[4]=0, IDENT_CHG[4]=1, INT_N stays 0; then pulse CHG_CLR[4] alone -> both flags 0, INT_N=1 one cycle later.
- Mask: IDENT_CHG[35]=1 with INT_MASK[35]=1 -> INT_N=1; drop INT_MASK[35] -> INT_N=0 next cycle; flag remains 1.
- Reset mid-debounce: PRSNT[0] toggled with stability count at 2, assert RESET_N=0 for 3 cycles then release -> all outputs 0 and INT_N=1 during reset; re-snapshot at next first tick with no CHG bits set.
